trans_d_writeback: RTL and testbench

- Write-back counterpart of the AXI read-side unpacker (256-bit beats to SRAM A/B/C enables).
- Accepts finished 8x8 result tiles of 32-bit accumulators from the systolic array and serialises them into 256-bit beats for the AXI write-data channel.
- Packing depends on data_type; burst length is fixed by type.
- Sits between systolic array drain logic and the AXI write master. Address generation belongs to the master.

---
 rtl/trans_d_writeback_pkg.sv | 43 ++++
 rtl/trans_d_writeback_if.sv | 24 ++
 rtl/trans_d_writeback_d_beat_select.sv | 32 +++
 rtl/trans_d_writeback.sv | 145 ++++++++++++++
 tb/tb_trans_d_writeback.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trans_d_writeback_pkg.sv
// Shared types, sizing constants and burst-length helpers for the result-tile
// write-back path (systolic drain -> AXI W channel).
package trans_d_writeback_pkg;

  typedef enum logic [1:0] {
    DT_FP32 = 2'b00,
    DT_FP16 = 2'b01,
    DT_INT8 = 2'b10,
    DT_INT4 = 2'b11
  } type_t;

  typedef enum logic [1:0] {
    RC_M32N8   = 2'b00,
    RC_M16N16  = 2'b01,
    RC_M8N32   = 2'b10,
    RC_INVALID = 2'b11
  } rc_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_SEND = 2'b10,
    S_FIN  = 2'b11
  } state_t;

  typedef logic [7:0][7:0][31:0] tile_t;

  localparam int TILES_PER_MAT     = 4;
  localparam int BEATS_PER_TILE_32 = 8;
  localparam int BEATS_PER_TILE_16 = 4;

  function automatic logic [5:0] total_beats(input type_t dt);
    return (dt == DT_FP16) ? 6'(TILES_PER_MAT * BEATS_PER_TILE_16)
                           : 6'(TILES_PER_MAT * BEATS_PER_TILE_32);
  endfunction

  // Index of the final sub-beat within one tile
  function automatic logic [2:0] last_sub(input type_t dt);
    return (dt == DT_FP16) ? 3'(BEATS_PER_TILE_16 - 1)
                           : 3'(BEATS_PER_TILE_32 - 1);
  endfunction

endpackage

// File: rtl/trans_d_writeback_if.sv
// Tile input and beat output handshakes of the write-back block.
// master = the write-back block, slave = its environment.
interface trans_d_writeback_if;

  logic                         tile_valid;
  logic                         tile_ready;
  trans_d_writeback_pkg::tile_t tile_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [255:0]                 out_data;
  logic                         out_last;
  logic [5:0]                   out_burst_num;

  modport master (
    input  tile_valid, tile_data, out_ready,
    output tile_ready, out_valid, out_data, out_last, out_burst_num
  );

  modport slave (
    output tile_valid, tile_data, out_ready,
    input  tile_ready, out_valid, out_data, out_last, out_burst_num
  );

endinterface

// File: rtl/trans_d_writeback_d_beat_select.sv
// Packing mux: picks one 256-bit beat out of a buffered 8x8 tile of 32-bit
// accumulators according to the element type.
module d_beat_select
  import trans_d_writeback_pkg::*;
(
  input  tile_t        tile_i,
  input  logic [2:0]   sub_i,
  input  type_t        dtype_i,
  output logic [255:0] beat_o
);

  logic [2:0] row_lo;
  logic [2:0] row_hi;

  always_comb begin
    beat_o = '0;
    row_lo = {sub_i[1:0], 1'b0};
    row_hi = {sub_i[1:0], 1'b1};
    // FP16 keeps only the low half of each accumulator, two rows per beat
    if (dtype_i == DT_FP16) begin
      for (int c = 0; c < 8; c++) begin
        beat_o[16*c +: 16]       = tile_i[row_lo][c][15:0];
        beat_o[128 + 16*c +: 16] = tile_i[row_hi][c][15:0];
      end
    end else begin
      for (int c = 0; c < 8; c++) begin
        beat_o[32*c +: 32] = tile_i[sub_i][c];
      end
    end
  end

endmodule

// File: rtl/trans_d_writeback.sv
// Serialises finished 8x8 result tiles into 256-bit AXI write-data beats,
// one tile buffered at a time; loading and sending never overlap.
module trans_d_writeback
  import trans_d_writeback_pkg::*;
#(
  parameter int TILES = TILES_PER_MAT
)(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  start,
  input  type_t data_type,
  input  rc_t   rc,
  output logic  busy,
  output logic  done,
  output logic  err,
  trans_d_writeback_if.master bus
);

  localparam int TCW = (TILES > 1) ? $clog2(TILES) : 1;

  state_t         state_q;
  type_t          dtype_q;
  rc_t            rc_q;
  logic [TCW-1:0] tile_cnt_q;
  logic [5:0]     beat_cnt_q;
  logic [2:0]     sub_q;
  tile_t          buf_q;
  logic [255:0]   out_data_q;
  logic [5:0]     out_burst_num_q;
  logic           busy_q, done_q, err_q;
  logic           tile_ready_q, out_valid_q, out_last_q;

  logic           tile_hs;
  logic           tile_end;
  logic [2:0]     sub_d;
  logic [5:0]     beat_idx_d;
  logic [255:0]   beat_d;

  assign tile_hs  = bus.tile_valid && tile_ready_q;
  assign tile_end = (sub_q == last_sub(dtype_q));

  // With no beat on the bus we present the current index, otherwise the next one
  assign sub_d      = out_valid_q ? sub_q + 3'd1      : sub_q;
  assign beat_idx_d = out_valid_q ? beat_cnt_q + 6'd1 : beat_cnt_q;

  d_beat_select u_beat_select (
    .tile_i  (buf_q),
    .sub_i   (sub_d),
    .dtype_i (dtype_q),
    .beat_o  (beat_d)
  );

  // Tile buffer holds data only; its content is irrelevant outside SEND
  always_ff @(posedge clk) begin
    if (tile_hs) buf_q <= bus.tile_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      dtype_q         <= DT_FP32;
      rc_q            <= RC_M32N8;
      tile_cnt_q      <= '0;
      beat_cnt_q      <= '0;
      sub_q           <= '0;
      out_data_q      <= '0;
      out_burst_num_q <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      tile_ready_q    <= 1'b0;
      out_valid_q     <= 1'b0;
      out_last_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (rc == RC_INVALID) begin
              err_q <= 1'b1;
            end else begin
              dtype_q      <= data_type;
              rc_q         <= rc;
              tile_cnt_q   <= '0;
              beat_cnt_q   <= '0;
              sub_q        <= '0;
              busy_q       <= 1'b1;
              tile_ready_q <= 1'b1;
              state_q      <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (tile_hs) begin
            tile_ready_q <= 1'b0;
            state_q      <= S_SEND;
          end
        end
        S_SEND: begin
          if (!out_valid_q || (bus.out_ready && !tile_end)) begin
            out_valid_q     <= 1'b1;
            out_data_q      <= beat_d;
            out_burst_num_q <= beat_idx_d;
            out_last_q      <= (beat_idx_d == total_beats(dtype_q) - 6'd1);
            sub_q           <= sub_d;
            beat_cnt_q      <= beat_idx_d;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            sub_q       <= '0;
            beat_cnt_q  <= beat_cnt_q + 6'd1;
            tile_cnt_q  <= tile_cnt_q + TCW'(1);
            if (tile_cnt_q == TCW'(TILES - 1)) begin
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else begin
              tile_ready_q <= 1'b1;
              state_q      <= S_LOAD;
            end
          end
        end
        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // An accepted matrix always carries a legal shape
  a_rc_legal: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != S_IDLE) |-> (rc_q != RC_INVALID));

  assign busy              = busy_q;
  assign done              = done_q;
  assign err               = err_q;
  assign bus.tile_ready    = tile_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_last      = out_last_q;
  assign bus.out_burst_num = out_burst_num_q;

endmodule

// File: tb/tb_trans_d_writeback.sv
// Scoreboard bench for trans_d_writeback: tile feeder pushes expected beats,
// a negedge monitor pops them on every W-channel handshake.
module tb_trans_d_writeback;
  import trans_d_writeback_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  start = 1'b0;
  type_t data_type = DT_FP32;
  rc_t   rc = RC_M32N8;
  logic  busy, done, err;

  trans_d_writeback_if bus();

  trans_d_writeback #(.TILES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .data_type (data_type),
    .rc        (rc),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [255:0] data;
    logic         last;
    logic [5:0]   burst;
  } beat_t;

  beat_t sb_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    hs_cnt = 0;
  int    stall_cnt = 0;
  bit    stall_mode = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] elem(input int mode, input int t, input int r, input int c);
    case (mode)
      0:       return 32'hF000_0000 | 32'((t << 16) | (r << 8) | c);
      1:       return 32'hABCD_0000 | 32'((t << 8) | (r << 4) | c);
      default: return 32'h5A00_0000 | 32'((t << 12) | (r << 6) | c);
    endcase
  endfunction

  task automatic push_tile(input int mode, input int t, input bit fp16);
    beat_t       b;
    logic [31:0] e0, e1;
    if (fp16) begin
      for (int k = 0; k < 4; k++) begin
        b = '0;
        for (int c = 0; c < 8; c++) begin
          e0 = elem(mode, t, 2*k, c);
          e1 = elem(mode, t, 2*k + 1, c);
          b.data[16*c +: 16]       = e0[15:0];
          b.data[128 + 16*c +: 16] = e1[15:0];
        end
        b.burst = 6'(4*t + k);
        b.last  = (4*t + k == 15);
        sb_q.push_back(b);
      end
    end else begin
      for (int r = 0; r < 8; r++) begin
        b = '0;
        for (int c = 0; c < 8; c++) b.data[32*c +: 32] = elem(mode, t, r, c);
        b.burst = 6'(8*t + r);
        b.last  = (8*t + r == 31);
        sb_q.push_back(b);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input type_t ty, input rc_t r);
    data_type = ty;
    rc        = r;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic feed_tile(input int mode, input int t, input bit fp16,
                           input bit pulse_in_load, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!bus.tile_ready && n < 200) begin
      tick();
      n++;
    end
    if (!bus.tile_ready) begin
      check("tile_ready_timeout", bus.tile_ready, 1);
      return;
    end
    if (pulse_in_load) begin
      pulse_start(DT_FP16, RC_M16N16);
      check("ready_after_ignored_start", bus.tile_ready, 1);
    end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) bus.tile_data[r][c] = elem(mode, t, r, c);
    bus.tile_valid = 1'b1;
    push_tile(mode, t, fp16);
    tick();
    bus.tile_valid = 1'b0;
    check("tile_ready_in_send", bus.tile_ready, 0);
    check("latency_valid_lo", bus.out_valid, 0);
    tick();
    check("latency_valid_hi", bus.out_valid, 1);
    ok = 1'b1;
  endtask

  task automatic wait_done(input int exp_hs);
    int n = 0;
    while (!done && n < 500) begin
      tick();
      n++;
    end
    check("done_seen", done, 1);
    check("busy_in_fin", busy, 1);
    check("handshake_count", hs_cnt, exp_hs);
    check("scoreboard_empty", sb_q.size(), 0);
    tick();
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
  endtask

  task automatic run_matrix(input type_t ty, input rc_t r, input int mode, input bit ignore_test);
    bit fp16;
    bit ok;
    fp16   = (ty == DT_FP16);
    hs_cnt = 0;
    pulse_start(ty, r);
    check("busy_after_start", busy, 1);
    check("tile_ready_after_start", bus.tile_ready, 1);
    for (int t = 0; t < 4; t++) begin
      feed_tile(mode, t, fp16, ignore_test && (t == 1), ok);
      if (!ok) return;
      if (ignore_test && t == 2) begin
        pulse_start(DT_FP16, RC_M16N16);
        check("busy_after_send_start", busy, 1);
      end
    end
    wait_done(fp16 ? 16 : 32);
  endtask

  // Out-ready driver: always ready, or a repeating stall pattern
  initial begin
    logic [7:0] pat;
    int         pidx;
    pat  = 8'b0110_1001;
    pidx = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_mode) begin
        bus.out_ready = pat[pidx];
        pidx = (pidx + 1) % 8;
      end else begin
        bus.out_ready = 1'b1;
      end
    end
  end

  // Monitor: compares each accepted beat and checks stability across stalls
  initial begin
    beat_t        e;
    logic         stall_prev;
    logic [255:0] held_d;
    logic [5:0]   held_b;
    logic         held_l;
    stall_prev = 1'b0;
    held_d = '0;
    held_b = '0;
    held_l = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else if (bus.out_valid) begin
        if (stall_prev) begin
          check("stall_data_hold", bus.out_data, held_d);
          check("stall_burst_hold", bus.out_burst_num, held_b);
          check("stall_last_hold", bus.out_last, held_l);
        end
        if (bus.out_ready) begin
          hs_cnt++;
          stall_prev = 1'b0;
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_beat: got burst %0d expected no beat", bus.out_burst_num);
          end else begin
            e = sb_q.pop_front();
            check("beat_data", bus.out_data, e.data);
            check("beat_burst", bus.out_burst_num, e.burst);
            check("beat_last", bus.out_last, e.last);
          end
        end else begin
          stall_prev = 1'b1;
          stall_cnt++;
          held_d = bus.out_data;
          held_b = bus.out_burst_num;
          held_l = bus.out_last;
        end
      end else begin
        if (stall_prev) check("valid_dropped_in_stall", bus.out_valid, 1);
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    bit ok;
    int n;
    bus.tile_valid = 1'b0;
    bus.tile_data  = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {busy, done, err, bus.tile_ready, bus.out_valid, bus.out_last}, 6'b0);
    check("reset_burst", bus.out_burst_num, 0);
    check("reset_data", bus.out_data, 0);
    rst_n = 1'b1;
    tick();

    run_matrix(DT_FP32, RC_M32N8, 0, 1'b0);
    run_matrix(DT_FP16, RC_M16N16, 1, 1'b0);

    stall_mode = 1'b1;
    stall_cnt  = 0;
    run_matrix(DT_INT8, RC_M8N32, 2, 1'b0);
    stall_mode = 1'b0;
    check("stalls_seen", stall_cnt > 0, 1);
    tick();

    pulse_start(DT_FP32, RC_INVALID);
    check("err_pulse", err, 1);
    check("err_busy", busy, 0);
    check("err_tile_ready", bus.tile_ready, 0);
    tick();
    check("err_one_cycle", err, 0);
    check("err_still_idle", {busy, bus.tile_ready}, 2'b00);

    hs_cnt = 0;
    pulse_start(DT_FP32, RC_M32N8);
    feed_tile(0, 0, 1'b0, 1'b0, ok);
    n = 0;
    while (!(bus.out_valid && bus.out_burst_num == 6'd5) && n < 50) begin
      tick();
      n++;
    end
    check("reached_beat5", bus.out_burst_num, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_ctrl", {busy, done, err, bus.tile_ready, bus.out_valid, bus.out_last}, 6'b0);
    check("async_reset_burst", bus.out_burst_num, 0);
    check("async_reset_data", bus.out_data, 0);
    check("beats_before_reset", hs_cnt, 5);
    sb_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_matrix(DT_FP32, RC_M32N8, 0, 1'b0);

    run_matrix(DT_FP32, RC_M8N32, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
